// File: rtl/uart_out_tx.sv
// rtl/uart_out_tx.sv - OUT-port byte holding register plus 8N1 UART serialiser
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1 framing).
module uart_out_tx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  output logic       ready,
  output logic       busy,
  output logic       tx,
  output logic [7:0] last_q,
  output logic       overrun
);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  localparam logic [15:0] CNT_MAX = 16'(CLKS_PER_BIT - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shifter_q;
  logic [7:0]  hold_q;
  logic        hold_full_q;
  logic        tx_q, tx_d;
  logic [7:0]  last_r;
  logic        overrun_r;

  logic accept;
  logic drain;
  logic bit_done;

  assign accept   = wr_en & ~hold_full_q;
  assign drain    = (state_q == IDLE) & hold_full_q;
  assign bit_done = (cnt_q == CNT_MAX);

  // State register together with the datapath registers it steers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 16'd0;
      idx_q       <= 3'd0;
      shifter_q   <= 8'h00;
      hold_q      <= 8'h00;
      hold_full_q <= 1'b0;
      tx_q        <= 1'b1;
      last_r      <= 8'h00;
      overrun_r   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
      if (accept) begin
        hold_q      <= wr_data;
        hold_full_q <= 1'b1;
        last_r      <= wr_data;
      end else if (drain) begin
        hold_full_q <= 1'b0;
      end
      if (drain) begin
        shifter_q <= hold_q;
      end
      if (wr_en && hold_full_q) begin
        overrun_r <= 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (hold_full_q) begin
          state_d = START;
          cnt_d   = 16'd0;
        end
      end
      START: begin
        if (bit_done) begin
          state_d = DATA;
          cnt_d   = 16'd0;
          idx_d   = 3'd0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      DATA: begin
        if (bit_done) begin
          cnt_d = 16'd0;
          if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_done) begin
          state_d = STOP;
          cnt_d   = 16'd0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
`endif
      STOP: begin
        if (bit_done) begin
          state_d = IDLE;
          cnt_d   = 16'd0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 16'd0;
      end
    endcase
  end

  // The line level is decoded from the upcoming state so tx can be a flop.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      START:     tx_d = 1'b0;
      DATA:      tx_d = shifter_q[idx_d];
`ifdef UART_TX_PARITY_EN
      PARITY:    tx_d = ^shifter_q;
`endif
      default:   tx_d = 1'b1;
    endcase
  end

  assign ready   = ~hold_full_q;
  assign busy    = hold_full_q | (state_q != IDLE);
  assign tx      = tx_q;
  assign last_q  = last_r;
  assign overrun = overrun_r;

endmodule

// File: tb/tb_uart_out_tx.sv
// tb/tb_uart_out_tx.sv - directed self-checking bench for uart_out_tx
// Honours UART_TX_PARITY_EN to run the 8E1 frame checks.
module tb_uart_out_tx;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FS = NBITS * CPB;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       ready;
  logic       busy;
  logic       tx;
  logic [7:0] last_q;
  logic       overrun;

  int vectors = 0;
  int errors = 0;

  uart_out_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .ready   (ready),
    .busy    (busy),
    .tx      (tx),
    .last_q  (last_q),
    .overrun (overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One tx sample per clock: start low, data LSB first, [parity], stop high.
  function automatic logic [127:0] frame_bits(input logic [7:0] d);
    logic [127:0] f;
    int b;
    f = '0;
    for (int k = 0; k < FS; k++) begin
      b = k / CPB;
      if (b == 0) f[k] = 1'b0;
      else if (b <= 8) f[k] = d[b-1];
`ifdef UART_TX_PARITY_EN
      else if (b == 9) f[k] = ^d;
`endif
      else f[k] = 1'b1;
    end
    return f;
  endfunction

  task automatic write_byte(input logic [7:0] d);
    @(negedge clk);
    wr_en = 1'b1;
    wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Waits (bounded) for tx to fall, then records n consecutive negedge samples.
  task automatic capture(input int n, output logic [127:0] cap, output int wait_cyc, output bit to);
    cap = '0;
    wait_cyc = 0;
    to = 1'b0;
    @(negedge clk);
    while (tx !== 1'b0) begin
      wait_cyc++;
      if (wait_cyc > 200) begin
        to = 1'b1;
        return;
      end
      @(negedge clk);
    end
    for (int k = 0; k < n; k++) begin
      cap[k] = tx;
      if (k < n - 1) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx_in_reset: got %b expected 1", tx); end
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    vectors++;
    if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b expected 1", tx); end
    vectors++;
    if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", ready); end
    vectors++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    vectors++;
    if (last_q !== 8'h00) begin errors++; $display("FAIL reset_last_q: got %h expected 00", last_q); end
    vectors++;
    if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
  endtask

  task automatic test_single(input logic [7:0] d);
    logic [127:0] cap;
    int wc;
    bit to;
    write_byte(d);
    vectors++;
    if (tx !== 1'b1 || busy !== 1'b1 || ready !== 1'b0) begin
      errors++;
      $display("FAIL single_accept_%h: got tx=%b busy=%b ready=%b expected tx=1 busy=1 ready=0", d, tx, busy, ready);
    end
    vectors++;
    if (last_q !== d) begin errors++; $display("FAIL single_last_q: got %h expected %h", last_q, d); end
    capture(FS, cap, wc, to);
    vectors++;
    if (to || wc != 0) begin
      errors++;
      $display("FAIL single_start_latency_%h: got wait=%0d timeout=%b expected wait=0", d, wc, to);
    end
    vectors++;
    if (cap !== frame_bits(d)) begin
      errors++;
      $display("FAIL single_frame_%h: got %h expected %h", d, cap, frame_bits(d));
    end
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || ready !== 1'b1 || tx !== 1'b1) begin
      errors++;
      $display("FAIL single_end_%h: got busy=%b ready=%b tx=%b expected 0 1 1", d, busy, ready, tx);
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] cap;
    logic [127:0] expv;
    int wc;
    bit to;
    write_byte(8'hA3);
    fork
      capture(2 * FS + 1, cap, wc, to);
      begin
        repeat (12) @(negedge clk);
        write_byte(8'h0F);
      end
    join
    expv = frame_bits(8'hA3) | (128'd1 << FS) | (frame_bits(8'h0F) << (FS + 1));
    vectors++;
    if (to || cap !== expv) begin
      errors++;
      $display("FAIL back_to_back_frames: got %h timeout=%b expected %h", cap, to, expv);
    end
    vectors++;
    if (overrun !== 1'b0) begin errors++; $display("FAIL back_to_back_overrun: got %b expected 0", overrun); end
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0) begin errors++; $display("FAIL back_to_back_idle: got busy=%b expected 0", busy); end
  endtask

  // The write landing on the drain edge sees ready=0 and is dropped; the
  // third write finds the holding register empty again and is queued.
  task automatic test_overrun();
    logic [127:0] cap;
    logic [127:0] expv;
    int wc;
    bit to;
    fork
      capture(2 * FS + 1, cap, wc, to);
      begin
        @(negedge clk); wr_en = 1'b1; wr_data = 8'h01;
        @(negedge clk); wr_data = 8'h02;
        @(negedge clk); wr_data = 8'h03;
        @(negedge clk); wr_en = 1'b0;
      end
    join
    expv = frame_bits(8'h01) | (128'd1 << FS) | (frame_bits(8'h03) << (FS + 1));
    vectors++;
    if (to || cap !== expv) begin
      errors++;
      $display("FAIL overrun_frames: got %h timeout=%b expected %h", cap, to, expv);
    end
    vectors++;
    if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_set: got %b expected 1", overrun); end
    vectors++;
    if (last_q !== 8'h03) begin errors++; $display("FAIL overrun_last_q: got %h expected 03", last_q); end
    repeat (20) @(negedge clk);
    vectors++;
    if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_sticky: got %b expected 1", overrun); end
    do_reset();
    @(negedge clk);
    vectors++;
    if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_cleared: got %b expected 0", overrun); end
  endtask

  task automatic test_reset_mid_frame();
    int lows;
    write_byte(8'hFF);
    repeat (14) @(negedge clk);
    vectors++;
    if (busy !== 1'b1) begin errors++; $display("FAIL midframe_busy_before: got %b expected 1", busy); end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (tx !== 1'b1 || busy !== 1'b0 || ready !== 1'b1) begin
      errors++;
      $display("FAIL midframe_async: got tx=%b busy=%b ready=%b expected 1 0 1", tx, busy, ready);
    end
    vectors++;
    if (last_q !== 8'h00) begin errors++; $display("FAIL midframe_last_q: got %h expected 00", last_q); end
    @(negedge clk);
    rst_n = 1'b1;
    lows = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) lows++;
    end
    vectors++;
    if (lows != 0) begin errors++; $display("FAIL midframe_no_resume: got %0d active cycles expected 0", lows); end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity(input logic [7:0] d, input logic par);
    logic [127:0] cap;
    int wc;
    bit to;
    write_byte(d);
    capture(FS, cap, wc, to);
    vectors++;
    if (to || cap[9*CPB] !== par) begin
      errors++;
      $display("FAIL parity_bit_%h: got %b timeout=%b expected %b", d, cap[9*CPB], to, par);
    end
    vectors++;
    if (cap !== frame_bits(d)) begin
      errors++;
      $display("FAIL parity_frame_%h: got %h expected %h", d, cap, frame_bits(d));
    end
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0) begin errors++; $display("FAIL parity_len_%h: got busy=%b expected 0", d, busy); end
  endtask
`endif

  initial begin
    test_reset();
    test_single(8'h55);
    test_single(8'hC4);
    test_back_to_back();
    test_overrun();
    test_reset_mid_frame();
`ifdef UART_TX_PARITY_EN
    test_parity(8'h07, 1'b1);
    test_parity(8'h03, 1'b0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
